// File: rtl/processing_unit.sv
// Datapath of the RISC stored-program machine: general registers, PC, IR,
// address register, ALU operand/flag registers, the two bus muxes and the ALU.
module processing_unit #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load_R0,
    input  logic                 Load_R1,
    input  logic                 Load_R2,
    input  logic                 Load_R3,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    input  logic                 Load_IR,
    input  logic                 Load_Add_R,
    input  logic                 Load_Reg_Y,
    input  logic                 Load_Reg_Z,
    input  logic [sel1_size-1:0] Sel_Bus_1_Mux,
    input  logic [sel2_size-1:0] Sel_Bus_2_Mux,
    input  logic [word_size-1:0] mem_word,
    output logic [word_size-1:0] instruction,
    output logic                 zero,
    output logic [word_size-1:0] address,
    output logic [word_size-1:0] Bus_1
);

    localparam logic [op_size-1:0] OP_ADD = op_size'(1);
    localparam logic [op_size-1:0] OP_SUB = op_size'(2);
    localparam logic [op_size-1:0] OP_AND = op_size'(3);
    localparam logic [op_size-1:0] OP_NOT = op_size'(4);

    logic [word_size-1:0] r0, r1, r2, r3;
    logic [word_size-1:0] pc, ir, add_r, reg_y;
    logic                 reg_z;
    logic [word_size-1:0] bus_2;
    logic [word_size-1:0] alu_out;
    logic                 alu_zero;
    logic [op_size-1:0]   opcode;

    assign opcode      = ir[word_size-1 -: op_size];
    assign instruction = ir;
    assign zero        = reg_z;
    assign address     = add_r;

    // NOTE: every combinational output gets a default first so no select
    // value can leave it unassigned and infer a latch.
    always_comb begin
        Bus_1 = '0;
        case (Sel_Bus_1_Mux)
            sel1_size'(0): Bus_1 = r0;
            sel1_size'(1): Bus_1 = r1;
            sel1_size'(2): Bus_1 = r2;
            sel1_size'(3): Bus_1 = r3;
            sel1_size'(4): Bus_1 = pc;
            default:       Bus_1 = '0;
        endcase
    end

    always_comb begin
        bus_2 = '0;
        case (Sel_Bus_2_Mux)
            sel2_size'(0): bus_2 = alu_out;
            sel2_size'(1): bus_2 = Bus_1;
            sel2_size'(2): bus_2 = mem_word;
            default:       bus_2 = '0;
        endcase
    end

    // Operand Y always comes from Reg_Y, operand B from Bus_1; SUB is B - Y.
    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = reg_y + Bus_1;
            OP_SUB:  alu_out = Bus_1 - reg_y;
            OP_AND:  alu_out = reg_y & Bus_1;
            OP_NOT:  alu_out = ~Bus_1;
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    // NOTE: state registers use non-blocking assignments so a register that is
    // both the Bus_1 source and the load target captures its pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0    <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            ir    <= '0;
            add_r <= '0;
            reg_y <= '0;
            reg_z <= 1'b0;
        end else begin
            if (Load_R0)    r0    <= bus_2;
            if (Load_R1)    r1    <= bus_2;
            if (Load_R2)    r2    <= bus_2;
            if (Load_R3)    r3    <= bus_2;
            if (Load_IR)    ir    <= bus_2;
            if (Load_Add_R) add_r <= bus_2;
            if (Load_Reg_Y) reg_y <= bus_2;
            if (Load_Reg_Z) reg_z <= alu_zero;
        end
    end

    // Load_PC takes priority over Inc_PC; increment wraps at the word width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (Load_PC) begin
            pc <= bus_2;
        end else if (Inc_PC) begin
            pc <= pc + word_size'(1);
        end
    end

endmodule

// File: doc/processing_unit.md
# processing_unit

Datapath of the RISC stored-program machine: four general registers R0–R3, PC, IR, address register Add_R, ALU operand register Reg_Y, zero-flag register Reg_Z, the two bus multiplexers and the ALU. Directly downstream of the control unit, it consumes the control unit's load, increment and select strobes. It returns `instruction` (IR) and `zero` (Reg_Z) to the control unit, and drives address and write data to the memory unit.

## Interface
- `word_size`, 8, datapath and memory word width
- `op_size`, 4, opcode field width, taken from IR[word_size-1 -: op_size]
- `sel1_size`, 3, Bus_1 select width
- `sel2_size`, 2, Bus_2 select width

- `clk`  in  1  single clock; all registers update on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `Load_R0`..`Load_R3`  in  1 each  load Rn from Bus_2
- `Load_PC`  in  1  load PC from Bus_2
- `Inc_PC`  in  1  PC <= PC+1
- `Load_IR`, `Load_Add_R`, `Load_Reg_Y`  in  1 each  load from Bus_2
- `Load_Reg_Z`  in  1  load the ALU zero flag
- `Sel_Bus_1_Mux`  in  sel1_size  0..3 = R0..R3, 4 = PC
- `Sel_Bus_2_Mux`  in  sel2_size  0 = alu_out, 1 = Bus_1, 2 = mem_word
- `mem_word`  in  word_size  memory read data
- `instruction`  out  word_size  IR contents
- `zero`  out  1  Reg_Z contents
- `address`  out  word_size  Add_R contents (memory address)
- `Bus_1`  out  word_size  Bus_1 value (memory write data)

## Operation
- **Bus_1** (combinational): selected register; select values 5–7 drive 0.
- **Bus_2** (combinational): alu_out, Bus_1 or mem_word; select value 3 drives 0.
- **ALU** (combinational): opcode is IR[7:4]; Y = Reg_Y, B = Bus_1.
  - 1 ADD: Y+B
  - 2 SUB: B−Y
  - 3 AND: Y&B
  - 4 NOT: ~B
  - any other opcode: 0
- **Arithmetic:** results truncated to word_size (modulo 2^8); no carry or overflow flag.
- **alu_zero** = (alu_out == 0). Reg_Z <= alu_zero when Load_Reg_Z.
- **Register loads:** each register holds its value unless its own strobe is asserted. Several loads in one cycle are legal; every asserted register captures the same Bus_2 value.
- **PC update:**
  - Load_PC and Inc_PC together: Load_PC wins and PC <= Bus_2.
  - Inc_PC alone: PC <= PC+1, wrapping 0xFF -> 0x00.
- **Read-modify-write:** a register may be both the Bus_1 source and the load target in one cycle (e.g. R2 <= R2 + Reg_Y). The pre-edge value is used.
- **Reset (rst low, asynchronous):** R0–R3, PC, IR, Add_R, Reg_Y = 0 and Reg_Z = 0. Therefore `instruction` = 0, `zero` = 0, `address` = 0. `Bus_1` = R0 = 0 when select is 0.
- **Reset mid-operation:** a load in flight is discarded. After rst deasserts, the first rising edge acts normally.

## Timing
- Register-to-output latency is zero: `instruction`, `zero` and `address` are direct register outputs.
- Control-to-state latency is one clock: a strobe asserted in cycle n is visible on outputs after edge n+1.
- Bus_1, Bus_2 and alu_out are purely combinational from selects and registers within the same cycle.
- **Fetch sequence as driven by the control unit:**
  - fet1 (sel1 = 4, sel2 = 1, Load_Add_R): Add_R <= PC.
  - fet2 (sel2 = 2, Load_IR, Inc_PC): IR <= mem_word, PC+1.
  - The new instruction is visible at the start of dec.
- **ALU ops:**
  - dec: Load_Reg_Y from src.
  - ex1: dest on Bus_1, sel2 = 0, Load_Rdest, Load_Reg_Z.
  - Result and flag appear together after the ex1 edge.
- Memory read data `mem_word` is treated as combinational from `address`.

## Test plan
- **Reset:** hold rst = 0 with arbitrary strobes, mem_word = 0xAA -> all outputs 0. Release rst; next edge with Load_IR, sel2 = 2 -> instruction = 0xAA.
- **Fetch:** PC = 0x05, mem_word = 0x1E.
  - fet1: Add_R = 0x05.
  - fet2: IR = 0x1E and PC = 0x06.
- **ADD wrap:**
  - R1 = 0xF0, R2 = 0x10, IR = 0x16.
  - Reg_Y <= R1, then ex1 with sel1 = 2 -> R2 = 0x00 and zero = 1.
- **SUB and AND:**
  - R3 = 0x09, Reg_Y = 0x03, IR = 0x2F.
  - ex1 -> R3 = 0x06, zero = 0.
  - With IR = 0x3F, Reg_Y = 0x0C, R3 = 0x0A -> R3 = 0x08.
- **NOT / select edge cases:**
  - R0 = 0xFF, IR = 0x40, sel2 = 0, Load_R1 + Load_Reg_Z -> R1 = 0x00, zero = 1.
  - sel1 = 6 -> Bus_1 = 0.
- **PC priority and reset mid-op:**
  - PC = 0xFF with Inc_PC -> 0x00.
  - Load_PC + Inc_PC, Bus_2 = 0x40 -> PC = 0x40.
  - rst pulse low between edges during Load_R0 -> R0 = 0.
